multisim_push_client: RTL and testbench

- Client-side push endpoint of a multisim channel: accepts DATA_WIDTH words from local logic over a ready-advisory/valid interface.
- Buffers accepted words in a small FIFO.
- Serialises each word onto a narrow link toward a named server as one header beat plus payload beats.
- Sits under quasi-static and streaming wrappers that drive data_vld one cycle after sampling data_rdy.

---
 rtl/multisim_pkg.sv | 20 ++
 rtl/multisim_sync_fifo.sv | 54 +++++
 rtl/multisim_push_client.sv | 136 +++++++++++++
 tb/tb_multisim_push_client.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multisim_pkg.sv
// Shared definitions for the multisim push client: beat-count helper,
// header field layout and the serializer state encoding.
package multisim_pkg;

    localparam int HDR_CNT_W  = 8;
    localparam int HDR_ID_W   = 16;
    localparam int BEAT_IDX_W = 8;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_HDR  = 2'd1,
        SER_PAY  = 2'd2
    } ser_state_t;

    // Payload beats needed to carry one data word over the link.
    function automatic int beat_count(input int data_w, input int link_w);
        return (data_w + link_w - 1) / link_w;
    endfunction

endpackage

// File: rtl/multisim_sync_fifo.sv
// Single-clock FIFO with combinational head read and an occupancy count.
// Callers gate wr_en/rd_en; a write while full is legal only with a read.
module multisim_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multisim_push_client.sv
// Client-side push endpoint: buffers pushed words and serialises each one
// onto the link as a header beat followed by LSB-first payload beats.
module multisim_push_client
    import multisim_pkg::*;
#(
    parameter string SERVER_RUNTIME_DIRECTORY = "../output_top",
    parameter int    DATA_WIDTH = 64,
    parameter int    FIFO_DEPTH = 4,
    parameter int    LINK_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           server_id,
    output logic                  data_rdy,
    input  logic                  data_vld,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  link_valid,
    input  logic                  link_ready,
    output logic [LINK_WIDTH-1:0] link_data,
    output logic                  link_last,
    output logic                  overflow
);

    localparam int P     = beat_count(DATA_WIDTH, LINK_WIDTH);
    localparam int SH_W  = P * LINK_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(P - 1);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      count_next;
    logic                  rdy_next;
    logic [SH_W-1:0]       word_ext;
    logic [LINK_WIDTH-1:0] hdr_word;

    ser_state_t            state;
    logic [SH_W-1:0]       shreg;
    logic [BEAT_IDX_W-1:0] beat_idx;

    // Link handshake: a beat transfers on any posedge with link_valid and
    // link_ready both high; while link_valid is high and link_ready is low
    // the beat (data, last, valid) is held unchanged.
    assign pop  = !fifo_empty &&
                  ((state == SER_IDLE) || (state == SER_PAY && link_ready && link_last));
    assign push = data_vld && (!fifo_full || pop);

    // Two free slots after this edge cover the registered-rdy round trip.
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign rdy_next   = (count_next <= CNT_W'(FIFO_DEPTH - 2));

    always_comb begin
        word_ext = '0;
        word_ext[DATA_WIDTH-1:0] = fifo_rd_data;
    end

    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_ID_W-1:0] = server_id;
        hdr_word[LINK_WIDTH-1 -: HDR_CNT_W] = HDR_CNT_W'(P);
    end

    multisim_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SER_IDLE;
            shreg      <= '0;
            beat_idx   <= '0;
            link_valid <= 1'b0;
            link_data  <= '0;
            link_last  <= 1'b0;
            data_rdy   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            data_rdy <= rdy_next;
            if (data_vld && !push) begin
                overflow <= 1'b1;
            end
            // A pop always starts a new word; server_id is captured here.
            if (pop) begin
                state      <= SER_HDR;
                shreg      <= word_ext;
                beat_idx   <= '0;
                link_valid <= 1'b1;
                link_data  <= hdr_word;
                link_last  <= 1'b0;
            end else begin
                unique case (state)
                    SER_HDR: begin
                        if (link_ready) begin
                            state     <= SER_PAY;
                            link_data <= shreg[LINK_WIDTH-1:0];
                            shreg     <= shreg >> LINK_WIDTH;
                            link_last <= (P == 1);
                            beat_idx  <= '0;
                        end
                    end
                    SER_PAY: begin
                        if (link_ready) begin
                            if (link_last) begin
                                state      <= SER_IDLE;
                                link_valid <= 1'b0;
                                link_data  <= '0;
                                link_last  <= 1'b0;
                            end else begin
                                beat_idx  <= beat_idx + BEAT_IDX_W'(1);
                                link_data <= shreg[LINK_WIDTH-1:0];
                                shreg     <= shreg >> LINK_WIDTH;
                                link_last <= ((beat_idx + BEAT_IDX_W'(1)) == LAST_IDX);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multisim_push_client.sv
// Scoreboarded bench for multisim_push_client: a 64-bit instance for the
// main scenarios and a 40-bit instance for the zero-extended last chunk.
module tb_multisim_push_client;

    localparam int DW  = 64;
    localparam int DW2 = 40;
    localparam int LW  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   server_id;

    logic          data_rdy, data_vld;
    logic [DW-1:0] data;
    logic          link_valid, link_ready, link_last, overflow;
    logic [LW-1:0] link_data;

    logic           data_rdy_b, data_vld_b;
    logic [DW2-1:0] data_b;
    logic           link_valid_b, link_ready_b, link_last_b, overflow_b;
    logic [LW-1:0]  link_data_b;

    int checks   = 0;
    int failures = 0;

    logic [LW:0] exp_q[$];
    logic [LW:0] exp_b_q[$];

    logic        stalled;
    logic [LW:0] stall_beat;
    logic        prod_done;

    always #5 clk = ~clk;

    multisim_push_client #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4),
        .LINK_WIDTH (LW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .server_id  (server_id),
        .data_rdy   (data_rdy),
        .data_vld   (data_vld),
        .data       (data),
        .link_valid (link_valid),
        .link_ready (link_ready),
        .link_data  (link_data),
        .link_last  (link_last),
        .overflow   (overflow)
    );

    multisim_push_client #(
        .DATA_WIDTH (DW2),
        .FIFO_DEPTH (4),
        .LINK_WIDTH (LW)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .server_id  (server_id),
        .data_rdy   (data_rdy_b),
        .data_vld   (data_vld_b),
        .data       (data_b),
        .link_valid (link_valid_b),
        .link_ready (link_ready_b),
        .link_data  (link_data_b),
        .link_last  (link_last_b),
        .overflow   (overflow_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Header {count=2, zero byte, id}, then low and high payload halves.
    function automatic void expect_word(input logic [63:0] w, input logic [15:0] id);
        exp_q.push_back({1'b0, 8'd2, 8'd0, id});
        exp_q.push_back({1'b0, w[31:0]});
        exp_q.push_back({1'b1, w[63:32]});
    endfunction

    task automatic push_word(input logic [63:0] w);
        data     = w;
        data_vld = 1'b1;
        @(posedge clk);
        #1;
        data_vld = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_b_q.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_b_q.size() != 0) begin
            failures++;
            $display("FAIL %s: actual=%0d beats pending required=0", name,
                     exp_q.size() + exp_b_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 64-bit instance: beat comparison plus stall hold.
    always @(negedge clk) begin
        logic [LW:0] want;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(link_valid), 64'd1);
                check("stall_hold", 64'({link_last, link_data}), 64'(stall_beat));
            end
            if (link_valid && link_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: actual=%0h required=none", {link_last, link_data});
                end else begin
                    want = exp_q.pop_front();
                    check("beat", 64'({link_last, link_data}), 64'(want));
                end
            end
            stalled    = link_valid && !link_ready;
            stall_beat = {link_last, link_data};
        end
    end

    always @(negedge clk) begin
        logic [LW:0] want_b;
        if (rst_n && link_valid_b && link_ready_b) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat_b: actual=%0h required=none", {link_last_b, link_data_b});
            end else begin
                want_b = exp_b_q.pop_front();
                check("beat_b", 64'({link_last_b, link_data_b}), 64'(want_b));
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [63:0] words2 [4];
        logic [63:0] words3 [6];
        logic        rdy_req [4];
        int          n;

        words2  = '{64'hA000_0000_0000_0001, 64'hA000_0000_0000_0002,
                    64'hA000_0000_0000_0003, 64'hA000_0000_0000_0004};
        words3  = '{64'hB1B1_B1B1_0000_0001, 64'hB2B2_B2B2_0000_0002,
                    64'hB3B3_B3B3_0000_0003, 64'hB4B4_B4B4_0000_0004,
                    64'hB5B5_B5B5_0000_0005, 64'hB6B6_B6B6_0000_0006};
        rdy_req = '{1'b1, 1'b1, 1'b1, 1'b0};

        rst_n        = 1'b0;
        server_id    = 16'h0005;
        data_vld     = 1'b0;
        data         = '0;
        link_ready   = 1'b1;
        data_vld_b   = 1'b0;
        data_b       = '0;
        link_ready_b = 1'b1;
        prod_done    = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_rdy", 64'(data_rdy), 64'd0);
        check("rst_link_valid", 64'(link_valid), 64'd0);
        check("rst_link_data", 64'(link_data), 64'd0);
        check("rst_link_last", 64'(link_last), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_link_valid_b", 64'(link_valid_b), 64'd0);
        rst_n = 1'b1;

        // Single word, header latency and beat order.
        @(posedge clk);
        #1;
        check("rdy_after_reset", 64'(data_rdy), 64'd1);
        expect_word(64'h1122_3344_5566_7788, 16'h0005);
        push_word(64'h1122_3344_5566_7788);
        @(negedge clk);
        check("latency_t", 64'(link_valid), 64'd0);
        @(negedge clk);
        check("latency_t1", 64'(link_valid), 64'd1);
        check("first_header", 64'(link_data), 64'h0200_0005);
        @(posedge clk);
        #1;
        wait_drain("drain_single", 20);

        // Four back-to-back pushes under stall: rdy falls, nothing dropped.
        link_ready = 1'b0;
        check("rdy_idle", 64'(data_rdy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            expect_word(words2[i], 16'h0005);
            push_word(words2[i]);
            check($sformatf("rdy_after_push%0d", i), 64'(data_rdy), 64'(rdy_req[i]));
        end
        check("ovf_burst4", 64'(overflow), 64'd0);
        link_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("no_gap_beat%0d", i), 64'(link_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        wait_drain("drain_burst4", 20);
        check("idle_after_burst", 64'(link_valid), 64'd0);

        // Overflow: the serializer holds one stalled word, so of six further
        // pushes four fill the FIFO and the 5th and 6th are dropped.
        link_ready = 1'b0;
        expect_word(64'hB0B0_B0B0_0000_0000, 16'h0005);
        push_word(64'hB0B0_B0B0_0000_0000);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_word(words3[i], 16'h0005);
            push_word(words3[i]);
            if (i == 3) check("ovf_before_drop", 64'(overflow), 64'd0);
        end
        check("ovf_set", 64'(overflow), 64'd1);
        check("rdy_full", 64'(data_rdy), 64'd0);
        link_ready = 1'b1;
        wait_drain("drain_overflow", 40);
        repeat (10) @(posedge clk);
        #1;
        check("no_extra_words", 64'(link_valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Reset during the second payload beat of a word.
        expect_word(64'hC0C0_C0C0_0000_00AA, 16'h0005);
        expect_word(64'hC1C1_C1C1_0000_00BB, 16'h0005);
        push_word(64'hC0C0_C0C0_0000_00AA);
        push_word(64'hC1C1_C1C1_0000_00BB);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!link_last && n < 10);
        check("reach_last_beat", 64'(link_last), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_link_valid", 64'(link_valid), 64'd0);
        check("midrst_link_data", 64'(link_data), 64'd0);
        check("midrst_fifo_empty", 64'(u_dut.fifo_empty), 64'd1);
        check("midrst_overflow", 64'(overflow), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdy_at_release", 64'(data_rdy), 64'd0);
        @(posedge clk);
        #1;
        check("rdy_after_release", 64'(data_rdy), 64'd1);
        expect_word(64'hD00D_F00D_1234_5678, 16'h0005);
        push_word(64'hD00D_F00D_1234_5678);
        wait_drain("drain_after_reset", 20);

        // 100 words, rdy-driven producer, random link stalls.
        server_id = 16'h00A7;
        fork
            begin
                int sent  = 0;
                int guard = 0;
                logic [63:0] w;
                while (sent < 100 && guard < 3000) begin
                    if (data_rdy) begin
                        w        = {$urandom, $urandom};
                        data     = w;
                        data_vld = 1'b1;
                        expect_word(w, 16'h00A7);
                        sent++;
                    end else begin
                        data_vld = 1'b0;
                    end
                    @(posedge clk);
                    #1;
                    guard++;
                end
                data_vld = 1'b0;
                check("rand_sent", 64'(sent), 64'd100);
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    link_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                link_ready = 1'b1;
            end
        join
        wait_drain("drain_random", 2000);
        check("rand_no_overflow", 64'(overflow), 64'd0);

        // 40-bit word: high chunk is zero-extended.
        server_id = 16'h0005;
        exp_b_q.push_back({1'b0, 32'h0200_0005});
        exp_b_q.push_back({1'b0, 32'hCDEF_0123});
        exp_b_q.push_back({1'b1, 32'h0000_00AB});
        data_b     = 40'hAB_CDEF_0123;
        data_vld_b = 1'b1;
        @(posedge clk);
        #1;
        data_vld_b = 1'b0;
        wait_drain("drain_dw40", 20);
        check("ovf_b", 64'(overflow_b), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
